mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: number of consecutive contested LSU grants after which the IF requester wins.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port if_req, input, 1: instruction-fetch read request.
REQ-006 SHALL have port if_addr, input, AW: fetch address.
REQ-007 SHALL have port if_gnt, output, 1: fetch request accepted this cycle.
REQ-008 SHALL have port if_rvalid, output, 1: fetch data valid.
REQ-009 SHALL have port if_rdata, output, 32: fetch data.
REQ-010 SHALL have port ls_cs, input, 1: LSU request, active-low.
REQ-011 SHALL have port ls_wr, input, 1: LSU direction, 1 = load, 0 = store.
REQ-012 SHALL have ports ls_addr (input, AW), ls_wdata (input, 32) and ls_mask (input, 4): LSU address, store data and byte mask.
REQ-013 SHALL have ports ls_gnt (output, 1), ls_rvalid (output, 1) and ls_rdata (output, 32): LSU accept, response valid (load data or store ack) and load data.
REQ-014 SHALL have ports mem_cs (output, 1, active-low), mem_wr (output, 1), mem_addr (output, AW), mem_wdata (output, 32) and mem_mask (output, 4): shared memory port.
REQ-015 SHALL have ports mem_gnt (input, 1), mem_rvalid (input, 1) and mem_rdata (input, 32): memory accept, response valid and read data.
REQ-016 SHALL have port err_spurious, output, 1: one-cycle pulse when mem_rvalid arrives with nothing outstanding.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_IF and WAIT_LS.
REQ-018 SHALL, in IDLE, select a winner combinationally and drive mem_* from it; with no request, mem_cs=1 and mem_addr, mem_wdata and mem_mask are 0.
REQ-019 SHALL arbitrate as follows: LSU wins a contested cycle (if_req=1, ls_cs=0) unless starve_cnt == STARVE_MAX, in which case IF wins.
REQ-020 SHALL drive IF requests on the memory port as mem_wr=1 and mem_mask=4'b1111.
REQ-021 SHALL, for an LSU request, pass ls_wr, ls_addr, ls_wdata and ls_mask unchanged to the memory port.
REQ-022 SHALL assert if_gnt/ls_gnt as mem_gnt AND the requester is selected AND state is IDLE; the grant is the handshake and occurs in the same cycle.
REQ-023 SHALL, on a grant, move to WAIT_IF or WAIT_LS at the next edge; in WAIT states mem_cs=1 and both gnt outputs are 0.
REQ-024 SHALL, in WAIT_x with mem_rvalid=1, route mem_rdata to x_rdata with x_rvalid=1 in the same cycle and return to IDLE at the next edge; new arbitration occurs no earlier than the following cycle.
REQ-025 SHALL drive the non-selected rdata output to 0 and both rdata outputs to 0 when their rvalid is 0.
REQ-026 SHALL treat mem_rvalid in IDLE as spurious: err_spurious=1 that cycle, no rvalid forwarded, state unchanged.
REQ-027 SHALL update starve_cnt as follows: +1 on an LSU grant while if_req=1; saturate at STARVE_MAX; clear to 0 on any IF grant; hold otherwise.
REQ-028 SHALL have no timeout; WAIT states persist until mem_rvalid arrives.
REQ-029 SHALL give minimum access latency of 1 cycle from grant to rvalid (mem_rvalid on the cycle after mem_gnt), so peak throughput is one access per 2 cycles.

Reset
REQ-030 SHALL, while rst_n=0, immediately force state=IDLE, starve_cnt=0, all gnt/rvalid/err outputs 0, mem_cs=1 and data outputs 0.
REQ-031 SHALL, on reset asserted during WAIT_x, drop the outstanding access; if its mem_rvalid arrives after release, it raises err_spurious and is not forwarded.

Structure
REQ-032 SHALL place the state enum (IDLE/WAIT_IF/WAIT_LS) and the STARVE_MAX default in shared package mem_arb_pkg.
REQ-033 SHALL contain one sub-module, mem_arb_prio, holding the winner select and starve_cnt; the FSM and muxing stay in the top module.

Verification
REQ-034 SHALL cover: IF-only read at if_addr=0x100, mem_gnt=1, mem_rdata=0xDEADBEEF one cycle later -> if_gnt on cycle 0, if_rvalid=1 with if_rdata=0xDEADBEEF on cycle 1.
REQ-035 SHALL cover: contested cycle with if_req=1 and LSU store (ls_wr=0, addr 0x204, mask 4'b0100) -> ls_gnt=1, mem_mask=4'b0100, mem_wr=0; IF granted after LSU ack.
REQ-036 SHALL cover: LSU request every IDLE cycle with if_req held at 1 and STARVE_MAX=4 -> exactly 4 LSU grants, then if_gnt; starve_cnt returns to 0.
REQ-037 SHALL cover: mem_gnt held 0 for 3 cycles -> mem_* held stable, state IDLE, no gnt; grant and transition on the 4th cycle.
REQ-038 SHALL cover: rst_n pulsed low in WAIT_LS, then mem_rvalid=1 after release -> err_spurious=1 for one cycle, ls_rvalid=0.
REQ-039 SHALL cover: mem_rvalid delayed 5 cycles in WAIT_IF while ls_cs=0 -> no ls_gnt until the cycle after if_rvalid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// the default starvation limit and a helper to size the starvation counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_LS = 2'd2
    } arb_state_t;

    localparam int STARVE_MAX_DEFAULT = 4;

    // Width needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner selection between the fetch and LSU requesters. The LSU is favoured
// on contested cycles until it has won STARVE_MAX contested grants in a row,
// after which fetch is let through once.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int CW         = cnt_width(STARVE_MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic          ls_req,
    input  logic          if_take,
    input  logic          ls_take,
    output logic          sel_if,
    output logic          sel_ls,
    output logic [CW-1:0] starve_cnt
);

    logic starved;

    // Combinational winner: LSU unless fetch has been starved to the limit.
    always_comb begin
        starved = if_req && (starve_cnt == CW'(STARVE_MAX));
        sel_ls  = ls_req && !starved;
        sel_if  = if_req && !sel_ls;
    end

    // Count contested LSU wins, saturating; any fetch grant clears the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (if_take) begin
            starve_cnt <= '0;
        end else if (ls_take && if_req && (starve_cnt != CW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between instruction fetch and
// the LSU. Handshake: a requester's gnt is high in the cycle its request is
// presented on mem_* and mem_gnt is high; that cycle is the transfer. The
// response comes back as x_rvalid (one cycle, same cycle as mem_rvalid).
// Only one access is ever outstanding, so the FSM waits in WAIT_IF/WAIT_LS
// until the memory answers; a response with nothing outstanding is flagged
// on err_spurious and dropped.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int AW         = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                if_req,
    input  logic [AW-1:0]                       if_addr,
    output logic                                if_gnt,
    output logic                                if_rvalid,
    output logic [31:0]                         if_rdata,
    input  logic                                ls_cs,
    input  logic                                ls_wr,
    input  logic [AW-1:0]                       ls_addr,
    input  logic [31:0]                         ls_wdata,
    input  logic [3:0]                          ls_mask,
    output logic                                ls_gnt,
    output logic                                ls_rvalid,
    output logic [31:0]                         ls_rdata,
    output logic                                mem_cs,
    output logic                                mem_wr,
    output logic [AW-1:0]                       mem_addr,
    output logic [31:0]                         mem_wdata,
    output logic [3:0]                          mem_mask,
    input  logic                                mem_gnt,
    input  logic                                mem_rvalid,
    input  logic [31:0]                         mem_rdata,
    output logic                                err_spurious,
    output arb_state_t                          dbg_state,
    output logic [cnt_width(STARVE_MAX)-1:0]    dbg_starve_cnt
);

    arb_state_t state, state_nxt;
    logic       sel_if, sel_ls;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .ls_req     (!ls_cs),
        .if_take    (if_gnt),
        .ls_take    (ls_gnt),
        .sel_if     (sel_if),
        .sel_ls     (sel_ls),
        .starve_cnt (dbg_starve_cnt)
    );

    assign dbg_state = state;

    // State register; reset abandons any outstanding access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, memory port mux, grants and response routing. Everything
    // is gated by rst_n so outputs are quiet while reset is held.
    always_comb begin
        state_nxt    = state;
        if_gnt       = 1'b0;
        ls_gnt       = 1'b0;
        if_rvalid    = 1'b0;
        ls_rvalid    = 1'b0;
        if_rdata     = '0;
        ls_rdata     = '0;
        mem_cs       = 1'b1;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_mask     = '0;
        err_spurious = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    err_spurious = mem_rvalid;
                    if (sel_if) begin
                        mem_cs   = 1'b0;
                        mem_wr   = 1'b1;
                        mem_addr = if_addr;
                        mem_mask = 4'b1111;
                        if_gnt   = mem_gnt;
                    end else if (sel_ls) begin
                        mem_cs    = 1'b0;
                        mem_wr    = ls_wr;
                        mem_addr  = ls_addr;
                        mem_wdata = ls_wdata;
                        mem_mask  = ls_mask;
                        ls_gnt    = mem_gnt;
                    end
                    if (if_gnt) begin
                        state_nxt = WAIT_IF;
                    end else if (ls_gnt) begin
                        state_nxt = WAIT_LS;
                    end
                end
                WAIT_IF: begin
                    if (mem_rvalid) begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                        state_nxt = IDLE;
                    end
                end
                WAIT_LS: begin
                    if (mem_rvalid) begin
                        ls_rvalid = 1'b1;
                        ls_rdata  = mem_rdata;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. The stimulus process plays both
// requesters and the memory, pushing each expected grant/response/error
// event into exp_q; a negedge monitor pops and compares every event the
// DUT produces. Cycle-exact properties are checked inline at the negedge.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int EW = 72;

    localparam logic [2:0] K_IF_GNT = 3'd1;
    localparam logic [2:0] K_LS_GNT = 3'd2;
    localparam logic [2:0] K_IF_RV  = 3'd3;
    localparam logic [2:0] K_LS_RV  = 3'd4;
    localparam logic [2:0] K_ERR    = 3'd5;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [31:0]   if_rdata;
    logic          ls_cs, ls_wr, ls_gnt, ls_rvalid;
    logic [AW-1:0] ls_addr;
    logic [31:0]   ls_wdata, ls_rdata;
    logic [3:0]    ls_mask;
    logic          mem_cs, mem_wr, mem_gnt, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [3:0]    mem_mask;
    logic          err_spurious;
    arb_state_t    dbg_state;
    logic [2:0]    dbg_starve_cnt;

    mem_port_arbiter #(.STARVE_MAX(4), .AW(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_gnt         (if_gnt),
        .if_rvalid      (if_rvalid),
        .if_rdata       (if_rdata),
        .ls_cs          (ls_cs),
        .ls_wr          (ls_wr),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_mask        (ls_mask),
        .ls_gnt         (ls_gnt),
        .ls_rvalid      (ls_rvalid),
        .ls_rdata       (ls_rdata),
        .mem_cs         (mem_cs),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_mask       (mem_mask),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .err_spurious   (err_spurious),
        .dbg_state      (dbg_state),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    // Scoreboard
    int tests = 0;
    int fails = 0;
    logic [EW-1:0] exp_q[$];

    function automatic logic [EW-1:0] mk(input logic [2:0] k, input logic wr,
                                         input logic [3:0] m, input logic [31:0] a,
                                         input logic [31:0] d);
        return {k, wr, m, a, d};
    endfunction

    task automatic check_evt(input string name, input logic [EW-1:0] act);
        logic [EW-1:0] e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: got event %h, expected no event", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                fails++;
                $display("FAIL %s: got %h, expected %h", name, act, e);
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every DUT event must match the head of the expected queue.
    always @(negedge clk) begin
        if (if_gnt === 1'b1)
            check_evt("if_gnt", mk(K_IF_GNT, mem_wr, mem_mask, mem_addr, mem_wdata));
        if (ls_gnt === 1'b1)
            check_evt("ls_gnt", mk(K_LS_GNT, mem_wr, mem_mask, mem_addr, mem_wdata));
        if (if_rvalid === 1'b1)
            check_evt("if_rvalid", mk(K_IF_RV, 1'b0, 4'h0, ls_rdata, if_rdata));
        if (ls_rvalid === 1'b1)
            check_evt("ls_rvalid", mk(K_LS_RV, 1'b0, 4'h0, if_rdata, ls_rdata));
        if (err_spurious === 1'b1)
            check_evt("err_spurious", mk(K_ERR, 1'b0, 4'h0, {30'd0, if_rvalid, ls_rvalid}, 32'd0));
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req     = 1'b0;
        if_addr    = '0;
        ls_cs      = 1'b1;
        ls_wr      = 1'b0;
        ls_addr    = '0;
        ls_wdata   = '0;
        ls_mask    = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with every input active: outputs must stay quiet.
        idle_inputs();
        rst_n      = 1'b0;
        if_req     = 1'b1;
        if_addr    = 32'h0000_0040;
        ls_cs      = 1'b0;
        ls_addr    = 32'h0000_0080;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        to_neg();
        chk("rst_if_gnt", 64'(if_gnt), 64'd0);
        chk("rst_ls_gnt", 64'(ls_gnt), 64'd0);
        chk("rst_mem_cs", 64'(mem_cs), 64'd1);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_err", 64'(err_spurious), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(IDLE));
        chk("rst_starve", 64'(dbg_starve_cnt), 64'd0);
        step();
        idle_inputs();
        rst_n = 1'b1;
        step();

        // Fetch-only read: grant now, data next cycle.
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        mem_gnt = 1'b1;
        exp_q.push_back(mk(K_IF_GNT, 1'b1, 4'hF, 32'h100, 32'd0));
        to_neg();
        chk("if_only_gnt_c0", 64'(if_gnt), 64'd1);
        step();
        idle_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        exp_q.push_back(mk(K_IF_RV, 1'b0, 4'h0, 32'd0, 32'hDEAD_BEEF));
        to_neg();
        chk("if_only_rvalid_c1", 64'(if_rvalid), 64'd1);
        chk("if_only_state", 64'(dbg_state), 64'(WAIT_IF));
        step();
        idle_inputs();
        to_neg();
        chk("if_only_back_idle", 64'(dbg_state), 64'(IDLE));
        step();

        // Contested: LSU store wins, then fetch after the store ack.
        if_req   = 1'b1;
        if_addr  = 32'h0000_0300;
        ls_cs    = 1'b0;
        ls_wr    = 1'b0;
        ls_addr  = 32'h0000_0204;
        ls_wdata = 32'h1234_5678;
        ls_mask  = 4'b0100;
        mem_gnt  = 1'b1;
        exp_q.push_back(mk(K_LS_GNT, 1'b0, 4'b0100, 32'h204, 32'h1234_5678));
        to_neg();
        chk("contest_mem_mask", 64'(mem_mask), 64'h4);
        chk("contest_mem_wr", 64'(mem_wr), 64'd0);
        step();
        ls_cs      = 1'b1;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hA5A5_A5A5;
        exp_q.push_back(mk(K_LS_RV, 1'b0, 4'h0, 32'd0, 32'hA5A5_A5A5));
        to_neg();
        chk("contest_starve1", 64'(dbg_starve_cnt), 64'd1);
        step();
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b1;
        exp_q.push_back(mk(K_IF_GNT, 1'b1, 4'hF, 32'h300, 32'd0));
        to_neg();
        step();
        idle_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_F00D;
        exp_q.push_back(mk(K_IF_RV, 1'b0, 4'h0, 32'd0, 32'h0BAD_F00D));
        to_neg();
        chk("contest_starve_clr", 64'(dbg_starve_cnt), 64'd0);
        step();

        // Starvation: four LSU loads win, then fetch is forced through.
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            if_req   = 1'b1;
            if_addr  = 32'h0000_0400;
            ls_cs    = 1'b0;
            ls_wr    = 1'b1;
            ls_addr  = 32'h0000_0500 + 32'(4 * i);
            ls_wdata = 32'(i);
            ls_mask  = 4'hF;
            mem_gnt  = 1'b1;
            exp_q.push_back(mk(K_LS_GNT, 1'b1, 4'hF, 32'h500 + 32'(4 * i), 32'(i)));
            to_neg();
            step();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h0000_1000 + 32'(i);
            exp_q.push_back(mk(K_LS_RV, 1'b0, 4'h0, 32'd0, 32'h1000 + 32'(i)));
            to_neg();
            chk($sformatf("starve_cnt_%0d", i), 64'(dbg_starve_cnt), 64'(i + 1));
            step();
        end
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b1;
        ls_addr    = 32'h0000_0510;
        exp_q.push_back(mk(K_IF_GNT, 1'b1, 4'hF, 32'h400, 32'd0));
        to_neg();
        chk("starve_if_wins", 64'(if_gnt), 64'd1);
        step();
        idle_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_2000;
        exp_q.push_back(mk(K_IF_RV, 1'b0, 4'h0, 32'd0, 32'h2000));
        to_neg();
        chk("starve_cnt_cleared", 64'(dbg_starve_cnt), 64'd0);
        step();

        // Memory stalls three cycles: request held stable, no grant.
        idle_inputs();
        ls_cs   = 1'b0;
        ls_wr   = 1'b1;
        ls_addr = 32'h0000_0600;
        ls_mask = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            to_neg();
            chk($sformatf("stall_cs_%0d", i), 64'(mem_cs), 64'd0);
            chk($sformatf("stall_addr_%0d", i), 64'(mem_addr), 64'h600);
            chk($sformatf("stall_gnt_%0d", i), 64'(ls_gnt), 64'd0);
            chk($sformatf("stall_state_%0d", i), 64'(dbg_state), 64'(IDLE));
            step();
        end
        mem_gnt = 1'b1;
        exp_q.push_back(mk(K_LS_GNT, 1'b1, 4'b0011, 32'h600, 32'd0));
        to_neg();
        step();
        idle_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h600D_CAFE;
        exp_q.push_back(mk(K_LS_RV, 1'b0, 4'h0, 32'd0, 32'h600D_CAFE));
        to_neg();
        chk("stall_wait_ls", 64'(dbg_state), 64'(WAIT_LS));
        step();

        // Reset during WAIT_LS, late response becomes spurious.
        idle_inputs();
        ls_cs   = 1'b0;
        ls_wr   = 1'b1;
        ls_addr = 32'h0000_0700;
        ls_mask = 4'hF;
        mem_gnt = 1'b1;
        exp_q.push_back(mk(K_LS_GNT, 1'b1, 4'hF, 32'h700, 32'd0));
        to_neg();
        step();
        idle_inputs();
        rst_n = 1'b0;
        to_neg();
        chk("midrst_state", 64'(dbg_state), 64'(IDLE));
        chk("midrst_mem_cs", 64'(mem_cs), 64'd1);
        step();
        rst_n = 1'b1;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        exp_q.push_back(mk(K_ERR, 1'b0, 4'h0, 32'd0, 32'd0));
        to_neg();
        chk("spur_err", 64'(err_spurious), 64'd1);
        chk("spur_ls_rvalid", 64'(ls_rvalid), 64'd0);
        chk("spur_ls_rdata", 64'(ls_rdata), 64'd0);
        step();
        mem_rvalid = 1'b0;
        to_neg();
        chk("spur_one_cycle", 64'(err_spurious), 64'd0);
        step();

        // Slow fetch response: LSU must wait until the cycle after if_rvalid.
        if_req  = 1'b1;
        if_addr = 32'h0000_0800;
        mem_gnt = 1'b1;
        exp_q.push_back(mk(K_IF_GNT, 1'b1, 4'hF, 32'h800, 32'd0));
        to_neg();
        step();
        if_req  = 1'b0;
        ls_cs   = 1'b0;
        ls_wr   = 1'b1;
        ls_addr = 32'h0000_0900;
        ls_mask = 4'hF;
        for (int i = 0; i < 5; i++) begin
            to_neg();
            chk($sformatf("slow_ls_gnt_%0d", i), 64'(ls_gnt), 64'd0);
            chk($sformatf("slow_mem_cs_%0d", i), 64'(mem_cs), 64'd1);
            step();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h9999_0000;
        exp_q.push_back(mk(K_IF_RV, 1'b0, 4'h0, 32'd0, 32'h9999_0000));
        to_neg();
        chk("slow_no_ls_gnt_rv", 64'(ls_gnt), 64'd0);
        step();
        mem_rvalid = 1'b0;
        exp_q.push_back(mk(K_LS_GNT, 1'b1, 4'hF, 32'h900, 32'd0));
        to_neg();
        chk("slow_ls_gnt_after", 64'(ls_gnt), 64'd1);
        step();
        idle_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1357_9BDF;
        exp_q.push_back(mk(K_LS_RV, 1'b0, 4'h0, 32'd0, 32'h1357_9BDF));
        to_neg();
        chk("slow_starve_hold", 64'(dbg_starve_cnt), 64'd0);
        step();
        idle_inputs();
        step();
        step();

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
